// File: rtl/exec_unit_pkg.sv
// Shared types for the CPU execute stage.
//   SequencerState : state encoding of the upstream CPU sequencer
//   ExecOp         : 4-bit execute opcodes (11..15 are illegal)
//   ExecState      : internal exec_unit FSM states
package exec_unit_pkg;

  typedef enum logic [2:0] {
    SIDLE   = 3'd0,
    SFETCH  = 3'd1,
    SDECODE = 3'd2,
    SREG    = 3'd3,
    SCALC   = 3'd4,
    SWB     = 3'd5,
    SERR    = 3'd6
  } SequencerState;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SHL   = 4'd5,
    OP_SHR   = 4'd6,
    OP_MUL   = 4'd7,
    OP_DIV   = 4'd8,
    OP_MOD   = 4'd9,
    OP_PASSB = 4'd10
  } ExecOp;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_DONE = 2'd2,
    EX_HOLD = 2'd3
  } ExecState;

endpackage

// File: rtl/exec_unit_if.sv
// Sequencer <-> execute-stage bundle.
//   q, opcode, op_a, op_b           : sequencer -> exec_unit
//   result, carry, done, err, busy  : exec_unit -> sequencer
// master = sequencer side, slave = exec_unit side.
interface exec_unit_if
  import exec_unit_pkg::*;
#(
  parameter int WIDTH = 8
);
  SequencerState    q;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             done;
  logic             err;
  logic             busy;

  modport master (
    output q, opcode, op_a, op_b,
    input  result, carry, done, err, busy
  );

  modport slave (
    input  q, opcode, op_a, op_b,
    output result, carry, done, err, busy
  );
endinterface

// File: rtl/exec_unit_muldiv.sv
// Iterative datapath: shift-add multiply / restoring divide, one step per
// cycle while step_i is high.
//   clk, rstn : clock, async active-low reset
//   load_i    : capture a_i/b_i and mode, clear the high half
//   step_i    : perform one iteration
//   div_i     : 1 = divide, 0 = multiply (sampled on load_i)
//   a_i, b_i  : multiplier/dividend, multiplicand/divisor
//   lo_o      : product low half / quotient
//   hi_o      : product high half / remainder
// lo_o/hi_o are the values after the current step, so the owner can
// capture the final result on the same edge as the last iteration.
module iter_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o
);

  logic [WIDTH-1:0] lo_q, hi_q, b_q;
  logic             div_q;
  logic [WIDTH-1:0] lo_d, hi_d;
  logic [WIDTH:0]   sum, shifted, diff;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    diff    = shifted - {1'b0, b_q};
    lo_d    = lo_q;
    hi_d    = hi_q;
    if (div_q) begin
      // diff[WIDTH] set means the trial subtraction borrowed: restore.
      if (!diff[WIDTH]) begin
        hi_d = diff[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shifted[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
    end
  end

  assign lo_o = lo_d;
  assign hi_o = hi_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lo_q  <= '0;
      hi_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load_i) begin
      lo_q  <= a_i;
      hi_q  <= '0;
      b_q   <= b_i;
      div_q <= div_i;
    end else if (step_i) begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Multicycle execute stage downstream of the CPU sequencer. Starts one
// operation per SCALC visit; single-cycle ALU ops finish the next cycle,
// MUL/DIV/MOD iterate WIDTH cycles in iter_muldiv.
//   clk, rstn : clock, async active-low reset
//   bus       : exec_unit_if.slave (q/opcode/op_a/op_b in;
//               result/carry/done/err/busy out, all registered)
module exec_unit
  import exec_unit_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rstn,
  exec_unit_if.slave  bus
);

  localparam int SHW = $clog2(WIDTH);

  ExecState         state_q;
  logic [3:0]       op_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q, done_q, err_q, busy_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_single, alu_iter;
  logic [WIDTH:0]   sum;
  logic             in_calc, load;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign in_calc = (bus.q == SCALC);

  always_comb begin
    alu_res    = '0;
    alu_carry  = 1'b0;
    alu_single = 1'b0;
    alu_iter   = 1'b0;
    sum        = {1'b0, bus.op_a} + {1'b0, bus.op_b};
    case (bus.opcode)
      OP_ADD:   begin alu_res = sum[WIDTH-1:0]; alu_carry = sum[WIDTH]; alu_single = 1'b1; end
      OP_SUB:   begin alu_res = bus.op_a - bus.op_b; alu_carry = (bus.op_a < bus.op_b); alu_single = 1'b1; end
      OP_AND:   begin alu_res = bus.op_a & bus.op_b; alu_single = 1'b1; end
      OP_OR:    begin alu_res = bus.op_a | bus.op_b; alu_single = 1'b1; end
      OP_XOR:   begin alu_res = bus.op_a ^ bus.op_b; alu_single = 1'b1; end
      OP_SHL:   begin alu_res = bus.op_a << bus.op_b[SHW-1:0]; alu_single = 1'b1; end
      OP_SHR:   begin alu_res = bus.op_a >> bus.op_b[SHW-1:0]; alu_single = 1'b1; end
      OP_PASSB: begin alu_res = bus.op_b; alu_single = 1'b1; end
      OP_MUL:   alu_iter = 1'b1;
      OP_DIV,
      OP_MOD:   alu_iter = (bus.op_b != '0);
      default:  ;
    endcase
  end

  assign load = (state_q == EX_IDLE) && in_calc && alu_iter;

  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rstn   (rstn),
    .load_i (load),
    .step_i ((state_q == EX_BUSY) && in_calc),
    .div_i  (bus.opcode != OP_MUL),
    .a_i    (bus.op_a),
    .b_i    (bus.op_b),
    .lo_o   (md_lo),
    .hi_o   (md_hi)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= EX_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        EX_IDLE: begin
          if (in_calc) begin
            if (alu_single) begin
              result_q <= alu_res;
              carry_q  <= alu_carry;
              done_q   <= 1'b1;
              state_q  <= EX_DONE;
            end else if (alu_iter) begin
              op_q     <= bus.opcode;
              cnt_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= EX_BUSY;
            end else begin
              err_q    <= 1'b1;
              state_q  <= EX_HOLD;
            end
          end
        end
        EX_BUSY: begin
          if (!in_calc) begin
            busy_q  <= 1'b0;
            state_q <= EX_IDLE;
          end else if (cnt_q == SHW'(WIDTH-1)) begin
            result_q <= (op_q == OP_MOD) ? md_hi : md_lo;
            carry_q  <= (op_q == OP_MUL) && (|md_hi);
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= EX_DONE;
          end else begin
            cnt_q <= cnt_q + SHW'(1);
          end
        end
        EX_DONE: begin
          done_q  <= 1'b0;
          state_q <= in_calc ? EX_HOLD : EX_IDLE;
        end
        EX_HOLD: begin
          done_q <= 1'b0;
          err_q  <= 1'b0;
          if (!in_calc) state_q <= EX_IDLE;
        end
        default: state_q <= EX_IDLE;
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_exec_unit.sv
// Directed, table-driven bench for exec_unit (WIDTH=8), plus hand-written
// sequences for reset during BUSY, abort during BUSY and HOLD behaviour.
module tb_exec_unit;
  import exec_unit_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  exec_unit_if #(.WIDTH(W)) bus ();

  exec_unit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cy;
    int           done_cyc;
    int           err_cyc;
    int           busy_n;
  } vec_t;

  localparam int NV = 22;
  vec_t vt [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an op in SREG, then hold q in SCALC for 14 cycles, recording the
  // SCALC cycle (1-based) of the first done/err and pulse counts.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int done_cyc, output int err_cyc, output int done_n,
                        output int err_n, output int busy_n, output int both_n);
    done_cyc = 0; err_cyc = 0; done_n = 0; err_n = 0; busy_n = 0; both_n = 0;
    bus.q = SREG; bus.opcode = op; bus.op_a = a; bus.op_b = b;
    tick();
    bus.q = SCALC;
    for (int c = 1; c <= 14; c++) begin
      if (bus.done) begin done_n++; if (done_cyc == 0) done_cyc = c; end
      if (bus.err)  begin err_n++;  if (err_cyc == 0)  err_cyc  = c; end
      if (bus.done && bus.err) both_n++;
      if (bus.busy) busy_n++;
      tick();
    end
    bus.q = SREG;
    tick();
  endtask

  // Start a MUL and stop in BUSY cycle 4 (SCALC cycle 5).
  task automatic start_mul_to_busy4();
    bus.q = SREG; bus.opcode = OP_MUL; bus.op_a = 8'h0F; bus.op_b = 8'h11;
    tick();
    bus.q = SCALC;
    for (int c = 1; c < 5; c++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int dc, ec, dn, en, bn, bothn;
    int ndone;

    //             op        a      b      res    cy    done err busy
    vt[0]  = '{OP_ADD,   8'hF0, 8'h20, 8'h10, 1'b1, 2,  0, 0};
    vt[1]  = '{OP_SUB,   8'h05, 8'h07, 8'hFE, 1'b1, 2,  0, 0};
    vt[2]  = '{OP_SHL,   8'h81, 8'h03, 8'h08, 1'b0, 2,  0, 0};
    vt[3]  = '{OP_SUB,   8'h07, 8'h05, 8'h02, 1'b0, 2,  0, 0};
    vt[4]  = '{OP_ADD,   8'h7F, 8'h01, 8'h80, 1'b0, 2,  0, 0};
    vt[5]  = '{OP_AND,   8'hF0, 8'h3C, 8'h30, 1'b0, 2,  0, 0};
    vt[6]  = '{OP_OR,    8'hF0, 8'h0C, 8'hFC, 1'b0, 2,  0, 0};
    vt[7]  = '{OP_XOR,   8'hFF, 8'h0F, 8'hF0, 1'b0, 2,  0, 0};
    vt[8]  = '{OP_SHR,   8'h80, 8'h0F, 8'h01, 1'b0, 2,  0, 0};
    vt[9]  = '{OP_PASSB, 8'h12, 8'hA5, 8'hA5, 1'b0, 2,  0, 0};
    vt[10] = '{OP_MUL,   8'h0F, 8'h11, 8'hFF, 1'b0, 10, 0, 8};
    vt[11] = '{OP_MUL,   8'h10, 8'h10, 8'h00, 1'b1, 10, 0, 8};
    vt[12] = '{OP_MUL,   8'hFF, 8'hFF, 8'h01, 1'b1, 10, 0, 8};
    vt[13] = '{OP_DIV,   8'hC8, 8'h07, 8'h1C, 1'b0, 10, 0, 8};
    vt[14] = '{OP_MOD,   8'hC8, 8'h07, 8'h04, 1'b0, 10, 0, 8};
    vt[15] = '{OP_DIV,   8'h05, 8'h00, 8'h04, 1'b0, 0,  2, 0};
    vt[16] = '{OP_ADD,   8'hFF, 8'h01, 8'h00, 1'b1, 2,  0, 0};
    vt[17] = '{4'hC,     8'h12, 8'h34, 8'h00, 1'b1, 0,  2, 0};
    vt[18] = '{OP_MOD,   8'h09, 8'h00, 8'h00, 1'b1, 0,  2, 0};
    vt[19] = '{4'hF,     8'h55, 8'hAA, 8'h00, 1'b1, 0,  2, 0};
    vt[20] = '{OP_DIV,   8'hFF, 8'h01, 8'hFF, 1'b0, 10, 0, 8};
    vt[21] = '{OP_MOD,   8'h07, 8'hC8, 8'h07, 1'b0, 10, 0, 8};

    bus.q = SIDLE; bus.opcode = '0; bus.op_a = '0; bus.op_b = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("reset result", 0, 32'(bus.result), 32'h0);
    chk("reset carry",  0, 32'(bus.carry),  32'h0);
    chk("reset done",   0, 32'(bus.done),   32'h0);
    chk("reset err",    0, 32'(bus.err),    32'h0);
    chk("reset busy",   0, 32'(bus.busy),   32'h0);
    tick();
    tick();
    rstn = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, dc, ec, dn, en, bn, bothn);
      chk("done cycle",  i, 32'(dc), 32'(vt[i].done_cyc));
      chk("done pulses", i, 32'(dn), (vt[i].done_cyc != 0) ? 32'd1 : 32'd0);
      chk("err cycle",   i, 32'(ec), 32'(vt[i].err_cyc));
      chk("err pulses",  i, 32'(en), (vt[i].err_cyc != 0) ? 32'd1 : 32'd0);
      chk("busy cycles", i, 32'(bn), 32'(vt[i].busy_n));
      chk("done&err",    i, 32'(bothn), 32'd0);
      chk("result",      i, 32'(bus.result), 32'(vt[i].res));
      chk("carry",       i, 32'(bus.carry),  32'(vt[i].cy));
    end

    // Reset asserted in BUSY cycle 4 clears outputs without a clock edge.
    start_mul_to_busy4();
    chk("mid-mul busy before reset", 0, 32'(bus.busy), 32'h1);
    rstn = 1'b0;
    #1;
    chk("mid-mul reset result", 0, 32'(bus.result), 32'h0);
    chk("mid-mul reset carry",  0, 32'(bus.carry),  32'h0);
    chk("mid-mul reset busy",   0, 32'(bus.busy),   32'h0);
    chk("mid-mul reset done",   0, 32'(bus.done),   32'h0);
    chk("mid-mul reset err",    0, 32'(bus.err),    32'h0);
    bus.q = SREG;
    tick();
    rstn = 1'b1;
    tick();

    // Abort: q leaves SCALC during BUSY; no done, result untouched.
    run_op(OP_ADD, 8'h33, 8'h11, dc, ec, dn, en, bn, bothn);
    chk("pre-abort result", 0, 32'(bus.result), 32'h44);
    start_mul_to_busy4();
    chk("abort busy before", 0, 32'(bus.busy), 32'h1);
    bus.q = SERR;
    tick();
    chk("abort busy after", 0, 32'(bus.busy), 32'h0);
    ndone = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.done) ndone++;
      tick();
    end
    chk("abort done pulses", 0, 32'(ndone), 32'h0);
    chk("abort result held", 0, 32'(bus.result), 32'h44);
    chk("abort carry held",  0, 32'(bus.carry),  32'h0);
    bus.q = SREG;
    tick();
    run_op(OP_ADD, 8'h01, 8'h02, dc, ec, dn, en, bn, bothn);
    chk("post-abort done cycle", 0, 32'(dc), 32'd2);
    chk("post-abort done pulses", 0, 32'(dn), 32'd1);
    chk("post-abort result", 0, 32'(bus.result), 32'h03);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Multicycle execute stage directly downstream of the CPU sequencer.
- Consumes the sequencer state `q` and the operands/opcode read in SREG, and computes the result while the sequencer sits in SCALC.
- Produces `done`, which drives the sequencer's `nxt_line` input, and `err`, which drives the sequencer's `err` input.
- Single-cycle ALU ops, plus iterative shift-add multiply and restoring divide/modulo.

Parameters:
- WIDTH, 8, datapath width in bits; must be a power of 2, ≥4.
- SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- rstn  in  1  reset, asynchronous and active-low.
- q  in  SequencerState  current sequencer state.
- opcode  in  4  operation select; stable from SREG through SCALC.
- op_a  in  WIDTH  operand A from register file.
- op_b  in  WIDTH  operand B from register file.
- result  out  WIDTH  operation result; valid when done=1, held until the next op starts.
- carry  out  1  ADD carry-out / SUB borrow / MUL high-half-nonzero; 0 for other ops.
- done  out  1  one-cycle pulse; connects to sequencer nxt_line.
- err  out  1  one-cycle pulse; connects to sequencer err.
- busy  out  1  high while in BUSY.

Behaviour:
- Reset (rstn=0, async): FSM=IDLE; result=0, carry=0, done=0, err=0, busy=0, iteration counter=0.
- Internal FSM states:
  - IDLE: waiting for an op.
  - BUSY: iterating a MUL/DIV/MOD.
  - DONE: done pulse cycle.
  - HOLD: waiting for q to leave SCALC.
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SHL by op_b[SHW-1:0], 6 SHR (logical) by op_b[SHW-1:0].
  - 7 MUL (low WIDTH bits), 8 DIV (unsigned quotient), 9 MOD (unsigned remainder), 10 PASSB.
  - 11–15 illegal.
- IDLE, on a posedge with q==SCALC, samples opcode/op_a/op_b:
  - Single-cycle op (0–6, 10): register result/carry; go to DONE with done=1 next cycle. done is visible in SCALC cycle 2.
  - MUL/DIV/MOD with a legal operand: load internal regs, counter=0; go to BUSY with busy=1.
  - Illegal opcode, or DIV/MOD with op_b==0: err=1 next cycle; go to HOLD; result and carry unchanged.
- BUSY: one iteration per cycle.
  - MUL: shift-add, with a 2·WIDTH-bit accumulator.
  - DIV/MOD: restoring division, one quotient bit per cycle.
  - On the edge where counter==WIDTH-1: register result/carry, done=1, busy=0, go to DONE.
  - Total: WIDTH BUSY cycles; done visible in SCALC cycle WIDTH+2.
- DONE: done high for exactly this one cycle. Next edge clears done and goes to HOLD, or to IDLE if q!=SCALC.
- HOLD: done=0, err=0. Returns to IDLE when q!=SCALC. This guarantees one op per SCALC visit.
- Abort: if q leaves SCALC while in BUSY (for example on a sequencer error), return to IDLE next edge; result and carry are not updated; no done.
- Arithmetic:
  - ADD carry = bit WIDTH of the (WIDTH+1)-bit sum.
  - SUB carry = (op_a < op_b).
  - MUL carry = |product[2W-1:W].
- done and err are never high in the same cycle. Both are registered, with no combinational path from inputs.

Decomposition:
- Shared package (params.svh) holds:
  - SequencerState (existing).
  - New ExecOp enum, 4 bits, codes above.
  - New ExecState enum: IDLE, BUSY, DONE, HOLD.
- One sub-module, iter_muldiv, holds the iterative datapath.
  - Inputs: clk, rstn, load, op select (mul/div), a, b.
  - Outputs: quotient/product_lo, remainder/product_hi.
  - Counter and FSM stay in exec_unit.

Test Plan:
- WIDTH=8, q: SREG→SCALC, ADD 0xF0+0x20 → done in SCALC cycle 2; result=0x10, carry=1; done width exactly 1 cycle.
- SUB 0x05−0x07 → result=0xFE, carry=1; SHL 0x81 by op_b=3 → result=0x08.
- MUL 0x0F·0x11 → busy for 8 cycles; done in SCALC cycle 10; result=0xFF, carry=0. MUL 0x10·0x10 → result=0x00, carry=1.
- DIV 200/7 → result=28 (0x1C). MOD 200/7 → result=4. Both with done in cycle 10.
- DIV by 0 → err=1 for one cycle in SCALC cycle 2; done never asserted; previous result held. Opcode 0xC → same err response.
- Mid-MUL rstn pulse low in BUSY cycle 4 → all outputs 0 immediately. Separately, q→SERR in BUSY cycle 4 → IDLE next edge with no done. Finally, q held in SCALC after done → no second done.
